// File: rtl/scl_pwr_seq_pkg.sv
// Shared types and helpers for the power-domain sequencer.
// Optional isolation outputs are enabled by defining PWR_SEQ_ISO_EN.
package scl_pwr_seq_pkg;

    localparam int MAX_DOM = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_UP_DLY,
        ST_UP_PG,
        ST_ON,
        ST_DN_DLY,
        ST_FAULT
    } pwr_seq_state_e;

    function automatic logic [IDX_W-1:0] highest_set(input logic [MAX_DOM-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DOM; i++) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] lowest_clear(input logic [MAX_DOM-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = MAX_DOM - 1; i >= 0; i--) begin
            if (!v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/scl_pwr_seq_ctrl_if.sv
// Control/status bundle between housekeeping (master) and the sequencer (slave).
// iso_o exists only when PWR_SEQ_ISO_EN is defined.
interface scl_pwr_seq_ctrl_if #(
    parameter int N_DOM = 3
);
    import scl_pwr_seq_pkg::*;

    // req_on/req_off are single-cycle pulses sampled on the rising clk edge; there is
    // no ready, requests that the current state ignores are simply dropped.
    logic             req_on;
    logic             req_off;
    logic [N_DOM-1:0] pg_i;
    logic [N_DOM-1:0] en_o;
`ifdef PWR_SEQ_ISO_EN
    logic [N_DOM-1:0] iso_o;
`endif
    logic             busy;
    logic             on_o;
    logic             fault;
    logic [2:0]       fault_idx;
    pwr_seq_state_e   state_o;

    modport master (
`ifdef PWR_SEQ_ISO_EN
        input  iso_o,
`endif
        output req_on, req_off, pg_i,
        input  en_o, busy, on_o, fault, fault_idx, state_o
    );

    modport slave (
`ifdef PWR_SEQ_ISO_EN
        output iso_o,
`endif
        input  req_on, req_off, pg_i,
        output en_o, busy, on_o, fault, fault_idx, state_o
    );

endinterface

// File: rtl/scl_pwr_seq_timer.sv
// Clear/enable saturating cycle counter with a terminal-count compare.
module scl_pwr_seq_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] tc_val_i,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) cnt_d = '0;
        else if (en_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/scl_pwr_seq_ctrl.sv
// Power-domain sequencer: ordered enable ramp-up/down gated by synchronized power-good.
// Define PWR_SEQ_ISO_EN to add per-domain isolation control.
module scl_pwr_seq_ctrl
    import scl_pwr_seq_pkg::*;
#(
    parameter int N_DOM    = 3,
    parameter int STEP_DLY = 4,
    parameter int PG_TMO   = 16
) (
    input logic               clk,
    input logic               resetn,
    scl_pwr_seq_ctrl_if.slave bus
);
    localparam int MAX_WAIT = (STEP_DLY > PG_TMO) ? STEP_DLY : PG_TMO;
    localparam int TMR_W    = $clog2(MAX_WAIT + 1);

    pwr_seq_state_e   state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, fault_idx_q, fault_idx_d, fault_src;
    logic [MAX_DOM-1:0] en_q, en_d, pg_s_pad;
    logic             fault_q, fault_d, go_fault, go_abort;
    logic [N_DOM-1:0] pg_meta_q, pg_s_q;
    logic             tmr_clr, tmr_en, tmr_tc;
    logic [TMR_W-1:0] tmr_tc_val;
`ifdef PWR_SEQ_ISO_EN
    logic [MAX_DOM-1:0] iso_q, iso_d;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pg_meta_q <= '0;
            pg_s_q    <= '0;
        end else begin
            pg_meta_q <= bus.pg_i;
            pg_s_q    <= pg_meta_q;
        end
    end

    // Nonexistent domains read as good so the reduction/priority helpers ignore them
    always_comb begin
        pg_s_pad              = '1;
        pg_s_pad[N_DOM-1:0]   = pg_s_q;
    end

    scl_pwr_seq_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .tc_val_i (tmr_tc_val),
        .tc_o     (tmr_tc)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        en_d        = en_q;
        fault_d     = fault_q;
        fault_idx_d = fault_idx_q;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b1;
        tmr_tc_val  = TMR_W'(STEP_DLY);
        go_fault    = 1'b0;
        go_abort    = 1'b0;
        fault_src   = '0;
`ifdef PWR_SEQ_ISO_EN
        iso_d       = iso_q;
`endif
        unique case (state_q)
            // Timer rests at zero in OFF/ON so the request cycle is the first settle cycle
            ST_OFF: begin
                tmr_clr = 1'b1;
                if (bus.req_on && !bus.req_off) begin
                    tmr_clr = 1'b0;
                    idx_d   = '0;
                    state_d = ST_UP_DLY;
                end
            end
            ST_UP_DLY: begin
                if (bus.req_off) go_abort = 1'b1;
                else if (tmr_tc) begin
                    en_d[idx_q] = 1'b1;
                    tmr_clr     = 1'b1;
                    state_d     = ST_UP_PG;
                end
            end
            ST_UP_PG: begin
                tmr_tc_val = TMR_W'(PG_TMO - 1);
                if (bus.req_off) go_abort = 1'b1;
                else if (pg_s_pad[idx_q]) begin
`ifdef PWR_SEQ_ISO_EN
                    if (iso_q[idx_q]) iso_d[idx_q] = 1'b0;
                    else
`endif
                    begin
                        tmr_clr = 1'b1;
                        if (idx_q == IDX_W'(N_DOM - 1)) state_d = ST_ON;
                        else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = ST_UP_DLY;
                        end
                    end
                end else if (tmr_tc) begin
                    go_fault  = 1'b1;
                    fault_src = idx_q;
                end
            end
            ST_ON: begin
                tmr_clr = 1'b1;
                if (!(&pg_s_pad)) begin
                    go_fault  = 1'b1;
                    fault_src = lowest_clear(pg_s_pad);
                end else if (bus.req_off) begin
                    tmr_clr = 1'b0;
                    idx_d   = IDX_W'(N_DOM - 1);
                    state_d = ST_DN_DLY;
                end
            end
            ST_DN_DLY: begin
                if (tmr_tc) begin
`ifdef PWR_SEQ_ISO_EN
                    if (!iso_q[idx_q]) begin
                        iso_d[idx_q] = 1'b1;
                        tmr_en       = 1'b0;
                    end else
`endif
                    begin
                        en_d[idx_q] = 1'b0;
                        tmr_clr     = 1'b1;
                        if (idx_q == '0) state_d = ST_OFF;
                        else             idx_d   = idx_q - 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                tmr_clr = 1'b1;
                if (bus.req_off) begin
                    fault_d = 1'b0;
                    state_d = ST_OFF;
                end
            end
            default: state_d = ST_OFF;
        endcase

        if (go_abort) begin
            tmr_clr = 1'b1;
            idx_d   = (|en_q) ? highest_set(en_q) : '0;
            state_d = (|en_q) ? ST_DN_DLY : ST_OFF;
        end
        if (go_fault) begin
            en_d        = '0;
            fault_d     = 1'b1;
            fault_idx_d = fault_src;
            tmr_clr     = 1'b1;
            state_d     = ST_FAULT;
`ifdef PWR_SEQ_ISO_EN
            iso_d       = '1;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_OFF;
            idx_q       <= '0;
            en_q        <= '0;
            fault_q     <= 1'b0;
            fault_idx_q <= '0;
`ifdef PWR_SEQ_ISO_EN
            iso_q       <= '1;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            en_q        <= en_d;
            fault_q     <= fault_d;
            fault_idx_q <= fault_idx_d;
`ifdef PWR_SEQ_ISO_EN
            iso_q       <= iso_d;
`endif
        end
    end

    assign bus.en_o      = en_q[N_DOM-1:0];
    assign bus.busy      = (state_q == ST_UP_DLY) || (state_q == ST_UP_PG) || (state_q == ST_DN_DLY);
    assign bus.on_o      = (state_q == ST_ON);
    assign bus.fault     = fault_q;
    assign bus.fault_idx = fault_idx_q;
    assign bus.state_o   = state_q;
`ifdef PWR_SEQ_ISO_EN
    assign bus.iso_o     = iso_q[N_DOM-1:0];
`endif

endmodule

// File: tb/tb_scl_pwr_seq_ctrl.sv
// Bench for scl_pwr_seq_ctrl: pg_i is en_o looped back through a 3-cycle delay and a mask.
module tb_scl_pwr_seq_ctrl;
    import scl_pwr_seq_pkg::*;

    localparam int N_DOM    = 3;
    localparam int STEP_DLY = 4;
    localparam int PG_TMO   = 16;
`ifdef PWR_SEQ_ISO_EN
    localparam int DN_GAP   = STEP_DLY + 2;
`else
    localparam int DN_GAP   = STEP_DLY + 1;
`endif

    logic clk = 1'b0;
    logic resetn;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [N_DOM-1:0] exp_q[$];
    logic [N_DOM-1:0] exp_v;
    logic [N_DOM-1:0] last_en = '0;
    logic [N_DOM-1:0] d1 = '0, d2 = '0, d3 = '0;
    logic [N_DOM-1:0] pg_mask = '1;

    scl_pwr_seq_ctrl_if #(.N_DOM(N_DOM)) bus ();

    scl_pwr_seq_ctrl #(.N_DOM(N_DOM), .STEP_DLY(STEP_DLY), .PG_TMO(PG_TMO)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // ---------------- clock / power-good loopback ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        d1 <= bus.en_o;
        d2 <= d1;
        d3 <= d2;
    end
    assign bus.pg_i = d3 & pg_mask;

    // ---------------- scoreboard: every en_o change pops one expectation ----------------
    always @(negedge clk) begin
        if (bus.en_o !== last_en) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL en_seq: unexpected en_o=%b (was %b)", bus.en_o, last_en);
            end else begin
                exp_v = exp_q.pop_front();
                if (bus.en_o !== exp_v) begin
                    tests_failed++;
                    $display("FAIL en_seq: got %b exp %b", bus.en_o, exp_v);
                end
            end
            last_en = bus.en_o;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic on, input logic off);
        @(posedge clk); #1;
        bus.req_on  = on;
        bus.req_off = off;
        @(posedge clk); #1;
        bus.req_on  = 1'b0;
        bus.req_off = 1'b0;
    endtask

    task automatic wait_en(input logic [N_DOM-1:0] v, input int budget, output int n);
        n = 0;
        while (bus.en_o !== v && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_state(input pwr_seq_state_e st, input int budget, output int n);
        n = 0;
        while (bus.state_o !== st && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        bus.req_on = 1'b0;
        bus.req_off = 1'b0;
        idle(3);
        resetn = 1'b1;
        idle(1);
        tests_run++; if (bus.en_o !== 3'b000) begin tests_failed++; $display("FAIL reset_en: got %b exp 000", bus.en_o); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
        tests_run++; if (bus.on_o !== 1'b0) begin tests_failed++; $display("FAIL reset_on: got %b exp 0", bus.on_o); end
        tests_run++; if (bus.fault !== 1'b0) begin tests_failed++; $display("FAIL reset_fault: got %b exp 0", bus.fault); end
        tests_run++; if (bus.fault_idx !== 3'd0) begin tests_failed++; $display("FAIL reset_fidx: got %0d exp 0", bus.fault_idx); end
        tests_run++; if (bus.state_o !== ST_OFF) begin tests_failed++; $display("FAIL reset_state: got %0d exp %0d", bus.state_o, ST_OFF); end
`ifdef PWR_SEQ_ISO_EN
        tests_run++; if (bus.iso_o !== 3'b111) begin tests_failed++; $display("FAIL reset_iso: got %b exp 111", bus.iso_o); end
`endif
    endtask

    task automatic test_power_up();
        int n;
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b111);
        pulse_req(1'b1, 1'b0);
        wait_en(3'b001, 20, n);
        tests_run++; if (n + 1 != STEP_DLY + 1) begin tests_failed++; $display("FAIL up_latency: got %0d exp %0d", n + 1, STEP_DLY + 1); end
        tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL up_busy: got %b exp 1", bus.busy); end
`ifdef PWR_SEQ_ISO_EN
        while (bus.pg_i[0] !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        n = 0;
        while (bus.iso_o[0] !== 1'b0 && n < 10) begin @(posedge clk); #1; n++; end
        tests_run++; if (n != 3) begin tests_failed++; $display("FAIL iso_release: got %0d exp 3", n); end
`endif
        wait_state(ST_ON, 150, n);
        tests_run++; if (bus.on_o !== 1'b1) begin tests_failed++; $display("FAIL up_on: got %b exp 1", bus.on_o); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL on_busy: got %b exp 0", bus.busy); end
        tests_run++; if (bus.en_o !== 3'b111) begin tests_failed++; $display("FAIL on_en: got %b exp 111", bus.en_o); end
    endtask

    task automatic test_power_down();
        int n;
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b000);
        pulse_req(1'b0, 1'b1);
        wait_en(3'b011, 30, n);
        tests_run++; if (n + 1 != DN_GAP) begin tests_failed++; $display("FAIL dn_gap2: got %0d exp %0d", n + 1, DN_GAP); end
        wait_en(3'b001, 30, n);
        tests_run++; if (n != DN_GAP) begin tests_failed++; $display("FAIL dn_gap1: got %0d exp %0d", n, DN_GAP); end
        wait_en(3'b000, 30, n);
        tests_run++; if (n != DN_GAP) begin tests_failed++; $display("FAIL dn_gap0: got %0d exp %0d", n, DN_GAP); end
        tests_run++; if (bus.state_o !== ST_OFF) begin tests_failed++; $display("FAIL dn_state: got %0d exp %0d", bus.state_o, ST_OFF); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL dn_busy: got %b exp 0", bus.busy); end
    endtask

    task automatic test_pg_timeout();
        int n;
        pg_mask = 3'b101;
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b000);
        pulse_req(1'b1, 1'b0);
        wait_en(3'b011, 60, n);
        wait_state(ST_FAULT, 40, n);
        tests_run++; if (n != PG_TMO) begin tests_failed++; $display("FAIL tmo_latency: got %0d exp %0d", n, PG_TMO); end
        tests_run++; if (bus.fault !== 1'b1) begin tests_failed++; $display("FAIL tmo_fault: got %b exp 1", bus.fault); end
        tests_run++; if (bus.fault_idx !== 3'd1) begin tests_failed++; $display("FAIL tmo_fidx: got %0d exp 1", bus.fault_idx); end
        tests_run++; if (bus.en_o !== 3'b000) begin tests_failed++; $display("FAIL tmo_en: got %b exp 000", bus.en_o); end
        pulse_req(1'b1, 1'b0);
        idle(STEP_DLY + 2);
        tests_run++; if (bus.state_o !== ST_FAULT || bus.fault !== 1'b1) begin tests_failed++; $display("FAIL fault_req_on: got state %0d fault %b exp state %0d fault 1", bus.state_o, bus.fault, ST_FAULT); end
        pulse_req(1'b0, 1'b1);
        tests_run++; if (bus.state_o !== ST_OFF || bus.fault !== 1'b0) begin tests_failed++; $display("FAIL fault_clear: got state %0d fault %b exp state %0d fault 0", bus.state_o, bus.fault, ST_OFF); end
        pg_mask = '1;
        idle(10);
    endtask

    task automatic test_pg_loss();
        int n;
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b111);
        pulse_req(1'b1, 1'b0);
        wait_state(ST_ON, 150, n);
        exp_q.push_back(3'b000);
        pg_mask = 3'b011;
        wait_state(ST_FAULT, 10, n);
        tests_run++; if (n != 3) begin tests_failed++; $display("FAIL loss_latency: got %0d exp 3", n); end
        tests_run++; if (bus.fault_idx !== 3'd2) begin tests_failed++; $display("FAIL loss_fidx: got %0d exp 2", bus.fault_idx); end
        tests_run++; if (bus.en_o !== 3'b000) begin tests_failed++; $display("FAIL loss_en: got %b exp 000", bus.en_o); end
`ifdef PWR_SEQ_ISO_EN
        tests_run++; if (bus.iso_o !== 3'b111) begin tests_failed++; $display("FAIL loss_iso: got %b exp 111", bus.iso_o); end
`endif
        pulse_req(1'b0, 1'b1);
        pg_mask = '1;
        idle(10);
    endtask

    task automatic test_abort();
        int n;
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b011);
        pulse_req(1'b1, 1'b0);
        wait_en(3'b011, 60, n);
        wait_state(ST_UP_DLY, 30, n);
        tests_run++; if (bus.state_o !== ST_UP_DLY) begin tests_failed++; $display("FAIL abort_setup: got %0d exp %0d", bus.state_o, ST_UP_DLY); end
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b000);
        pulse_req(1'b0, 1'b1);
        wait_en(3'b001, 30, n);
        wait_en(3'b000, 30, n);
        tests_run++; if (bus.state_o !== ST_OFF || bus.en_o !== 3'b000) begin tests_failed++; $display("FAIL abort_end: got state %0d en %b exp state %0d en 000", bus.state_o, bus.en_o, ST_OFF); end
        idle(10);
    endtask

    task automatic test_back_to_back();
        int n;
        pulse_req(1'b1, 1'b1);
        idle(STEP_DLY + 3);
        tests_run++; if (bus.state_o !== ST_OFF || bus.en_o !== 3'b000) begin tests_failed++; $display("FAIL both_off: got state %0d en %b exp state %0d en 000", bus.state_o, bus.en_o, ST_OFF); end
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b111);
        pulse_req(1'b1, 1'b0);
        wait_state(ST_ON, 150, n);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b000);
        pulse_req(1'b1, 1'b1);
        wait_en(3'b011, 30, n);
        tests_run++; if (n + 1 != DN_GAP) begin tests_failed++; $display("FAIL both_on_dn: got %0d exp %0d", n + 1, DN_GAP); end
        wait_en(3'b000, 60, n);
        tests_run++; if (bus.state_o !== ST_OFF) begin tests_failed++; $display("FAIL both_on_end: got %0d exp %0d", bus.state_o, ST_OFF); end
        idle(10);
    endtask

    task automatic test_reset_mid();
        int n;
        exp_q.push_back(3'b001);
        pulse_req(1'b1, 1'b0);
        wait_en(3'b001, 20, n);
        exp_q.push_back(3'b000);
        idle(2);
        #2;
        resetn = 1'b0;
        #1;
        tests_run++; if (bus.en_o !== 3'b000) begin tests_failed++; $display("FAIL rst_mid_en: got %b exp 000", bus.en_o); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy: got %b exp 0", bus.busy); end
        tests_run++; if (bus.state_o !== ST_OFF) begin tests_failed++; $display("FAIL rst_mid_state: got %0d exp %0d", bus.state_o, ST_OFF); end
        idle(2);
        resetn = 1'b1;
        idle(5);
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_power_down();
        idle(10);
        test_pg_timeout();
        test_pg_loss();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL exp_drain: got %0d pending exp 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
